fetch_pc_controller: RTL and testbench

Drives the next-PC side of the program counter interface: produces PC_In and PC_En for program_counter from its fed-back PC_Out, the hazard unit's fetch stall, and execute-stage branch/jump redirects. Holds a redirect that arrives during a stall until the stall releases, raises pipeline flushes when a redirect is applied, and halts fetch on a misaligned target. Sits in the fetch stage beside program_counter.

---
 rtl/fetch_pc_controller_pkg.sv | 6 +
 rtl/fetch_pc_controller_next_pc_adder.sv | 11 +
 rtl/fetch_pc_controller.sv | 97 +++++++++
 tb/tb_fetch_pc_controller.sv | 112 +++++++++++
 4 files changed

// File: rtl/fetch_pc_controller_pkg.sv
// fetch_pc_controller_pkg: shared fetch-stage types and constants
package fetch_pc_controller_pkg;
  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, HOLD, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_pc_controller_next_pc_adder.sv
// next_pc_adder: sequential PC increment, modulo 2^PC_WIDTH
module next_pc_adder
  import fetch_pc_controller_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next
);
  assign pc_next = pc + PC_WIDTH'(PC_STEP);
endmodule

// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller: next-PC selection with stall-held redirects, flushes and misalignment fault
module fetch_pc_controller
  import fetch_pc_controller_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned         PC_STEP      = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [PC_WIDTH-1:0] PC_Out,
  input  logic                Stall_F,
  input  logic                Redirect_E,
  input  logic [PC_WIDTH-1:0] Target_E,
  output logic [PC_WIDTH-1:0] PC_In,
  output logic                PC_En,
  output logic                Flush_D,
  output logic                Flush_E,
  output logic                Misaligned_Fault,
  output logic [31:0]         Redirect_Count
);
  fetch_state_t        state, state_nxt;
  logic                pend_valid, pend_valid_nxt;
  logic [PC_WIDTH-1:0] pend_target, pend_target_nxt, pc_seq;
  logic                aligned, fault_set, count_inc;

  next_pc_adder #(.PC_STEP(PC_STEP)) u_adder (.pc(PC_Out), .pc_next(pc_seq));

  assign aligned = Target_E[1:0] == 2'b00;

  // Next-PC selection, flush generation and next-state; a held redirect replays when the stall drops
  always_comb begin
    state_nxt       = state;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    fault_set       = 1'b0;
    count_inc       = 1'b0;
    PC_In           = pc_seq;
    PC_En           = 1'b0;
    Flush_D         = 1'b0;
    Flush_E         = 1'b0;
    if (RST) PC_In = RESET_VECTOR;
    else
      case (state)
        BOOT: begin
          PC_In     = RESET_VECTOR;
          PC_En     = 1'b1;
          state_nxt = RUN;
        end
        RUN, HOLD: begin
          if (Redirect_E && (state == RUN || !Stall_F || !aligned)) begin
            Flush_D        = 1'b1;
            Flush_E        = 1'b1;
            pend_valid_nxt = 1'b0;
            if (aligned) begin
              PC_In     = Target_E;
              PC_En     = 1'b1;
              count_inc = 1'b1;
              state_nxt = RUN;
            end else begin
              fault_set = 1'b1;
              state_nxt = FAULT;
            end
          end else if (Redirect_E) begin
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = Target_E;
            Flush_E         = 1'b1;
          end else if (Stall_F) state_nxt = HOLD;
          else begin
            PC_In          = pend_valid ? pend_target : pc_seq;
            PC_En          = 1'b1;
            Flush_D        = pend_valid;
            count_inc      = pend_valid;
            pend_valid_nxt = 1'b0;
            state_nxt      = RUN;
          end
        end
        default: ;
      endcase
  end

  // State, pending redirect, sticky fault and saturating redirect counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= BOOT;
      pend_valid       <= 1'b0;
      pend_target      <= '0;
      Misaligned_Fault <= 1'b0;
      Redirect_Count   <= '0;
    end else begin
      state       <= state_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      if (fault_set) Misaligned_Fault <= 1'b1;
      if (count_inc && Redirect_Count != 32'hFFFF_FFFF) Redirect_Count <= Redirect_Count + 32'd1;
    end
  end
endmodule

// File: tb/tb_fetch_pc_controller.sv
// tb_fetch_pc_controller: directed and random checks against a queue-based fetch model
module tb_fetch_pc_controller;
  localparam logic [31:0] RV = 32'h0000_1000;
  logic        CLK = 0, RST = 1, Stall_F = 0, Redirect_E = 0;
  logic [31:0] Target_E = 0, PC_Out = 0, PC_In, Redirect_Count;
  logic        PC_En, Flush_D, Flush_E, Misaligned_Fault;
  int          n_checks = 0, n_fail = 0;

  // model of the environment and the expected behaviour
  logic [31:0] m_pc = 0, m_count = 0;
  logic [31:0] m_pend[$];
  bit          m_boot = 1, m_run = 0, m_fault = 0, m_stalled = 0;

  fetch_pc_controller #(.RESET_VECTOR(RV), .PC_STEP(4)) dut (
    .CLK(CLK), .RST(RST), .PC_Out(PC_Out), .Stall_F(Stall_F), .Redirect_E(Redirect_E),
    .Target_E(Target_E), .PC_In(PC_In), .PC_En(PC_En), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .Misaligned_Fault(Misaligned_Fault), .Redirect_Count(Redirect_Count)
  );

  always #5 CLK = ~CLK;

  // stand-in for program_counter: resets to 0, loads PC_In when enabled
  always_ff @(posedge CLK) PC_Out <= RST ? 32'h0 : (PC_En ? PC_In : PC_Out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit stall, input bit redir, input logic [31:0] tgt);
    logic [31:0] e_in;
    bit e_en, e_fd, e_fe, applied;
    @(negedge CLK);
    RST = rst; Stall_F = stall; Redirect_E = redir; Target_E = tgt;
    #1;
    e_in = RV; e_en = 0; e_fd = 0; e_fe = 0; applied = 0;
    chk("pc_out", PC_Out, m_pc);
    chk("fault", {31'b0, Misaligned_Fault}, {31'b0, m_fault});
    chk("count", Redirect_Count, m_count);
    if (rst) begin
      e_in = RV;
    end else if (m_boot) begin
      e_en = 1; e_in = RV; m_boot = 0; m_run = 1;
    end else if (m_run) begin
      if (redir && (tgt % 4 != 0)) begin
        e_fd = 1; e_fe = 1; m_fault = 1; m_run = 0; m_pend.delete();
      end else if (redir && m_stalled && stall) begin
        m_pend.delete(); m_pend.push_back(tgt); e_fe = 1;
      end else if (redir) begin
        e_fd = 1; e_fe = 1; e_en = 1; e_in = tgt; applied = 1; m_pend.delete(); m_stalled = 0;
      end else if (stall) begin
        m_stalled = 1;
      end else if (m_pend.size() > 0) begin
        e_en = 1; e_fd = 1; e_in = m_pend.pop_front(); applied = 1; m_stalled = 0;
      end else begin
        e_en = 1; e_in = m_pc + 4; m_stalled = 0;
      end
    end
    chk("pc_en", {31'b0, PC_En}, {31'b0, e_en});
    chk("flush_d", {31'b0, Flush_D}, {31'b0, e_fd});
    chk("flush_e", {31'b0, Flush_E}, {31'b0, e_fe});
    if (e_en || rst) chk("pc_in", PC_In, e_in);
    @(posedge CLK);
    if (rst) begin
      m_pc = 0; m_count = 0; m_pend.delete();
      m_boot = 1; m_run = 0; m_fault = 0; m_stalled = 0;
    end else begin
      if (e_en) m_pc = e_in;
      if (applied && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    end
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h40);
    step(0, 1, 1, 32'h8);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_2040);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h0000_3000);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h0000_5000);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_2042);
    for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 1), 1, 32'h100);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      bit r;
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) t[1:0] = 2'($urandom_range(1, 3));
      r = ($urandom_range(0, 79) == 0) || (m_fault && $urandom_range(0, 4) == 0);
      step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, t);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
